// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: widths, reset PC, NOP, FSM states.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural fetch PC: increment/redirect mux plus target alignment check.
// MISALIGN_TRAP_EN keeps misaligned targets and flags them; otherwise targets are aligned down.
module fetch_pc_reg
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            incr_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] target_eff;

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign_o = |target_i[1:0];
    target_eff = target_i;
`else
    misalign_o = 1'b0;
    target_eff = target_i & ~XLEN'(3);
`endif
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_eff;
    end else if (incr_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-side PC controller: one-outstanding imem fetch, IF/ID delivery, redirect flush.
// Optional MISALIGN_TRAP_EN raises trap_o on misaligned redirect targets.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            flush_o,
  output logic            trap_o
);

  fetch_state_e    state_q, state_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;
  logic            park_q, park_d;
  logic            pc_incr;
  logic            misalign;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect_i (ex_redirect_i),
    .target_i   (ex_target_i),
    .incr_i     (pc_incr),
    .pc_o       (pc),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    flush_d    = 1'b0;
    trap_d     = 1'b0;
    park_d     = park_q;
    pc_incr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if_valid_d = 1'b0;
        if (imem_ack_i) begin
          if_valid_d = 1'b1;
          if_instr_d = imem_rdata_i;
          if_pc_d    = pc;
          pc_incr    = 1'b1;
          if (stall_i) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_DISCARD: begin
        if (imem_ack_i) begin
          state_d = park_q ? ST_HOLD : ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (!stall_i && !park_q) begin
          state_d    = ST_FETCH;
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect overrides everything above; an ack in this same cycle is dropped,
    // while an unacked outstanding request must drain through DISCARD first.
    if (ex_redirect_i) begin
      flush_d    = 1'b1;
      trap_d     = misalign;
      park_d     = misalign;
      pc_incr    = 1'b0;
      if_valid_d = 1'b0;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if (((state_q == ST_FETCH) || (state_q == ST_DISCARD)) && !imem_ack_i) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = misalign ? ST_HOLD : ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
      park_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
      park_q     <= park_d;
    end
  end

  assign imem_req_o  = (state_q == ST_FETCH);
  assign imem_addr_o = pc;
  assign if_valid_o  = if_valid_q;
  assign if_instr_o  = if_instr_q;
  assign if_pc_o     = if_pc_q;
  assign flush_o     = flush_q;
  assign trap_o      = trap_q;

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Fetch-side program-counter controller. It consumes the resolved taken/not-taken decision and target address from the execute stage, and owns the architectural fetch PC. It issues one-outstanding-request instruction fetches, delivers instructions to the IF/ID register, and generates the pipeline flush on redirect. It sits between the instruction memory port and the decode stage, downstream of the hazard unit.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  IF/ID hold from hazard unit
ex_redirect_i  in  1  execute stage: branch taken or jump (one-cycle pulse per instruction)
ex_target_i  in  XLEN  redirect target, valid with ex_redirect_i
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address, word aligned
imem_ack_i  in  1  response valid (>=1 cycle after accepted req)
imem_rdata_i  in  32  fetched instruction
if_valid_o  out  1  instruction valid to IF/ID
if_instr_o  out  32  instruction to IF/ID
if_pc_o  out  XLEN  PC of if_instr_o
flush_o  out  1  kill IF/ID and ID/EX contents
trap_o  out  1  misaligned-target trap (feature only, else tied 0)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=IDLE; imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=32'h0000_0013 (NOP), if_pc_o=0, flush_o=0, trap_o=0.
- States: IDLE, FETCH, DISCARD, HOLD.
- IDLE: first cycle after reset release -> assert imem_req_o with pc, go FETCH.
- FETCH: req held high until imem_ack_i; on ack with no redirect: capture instr/pc into if_*, if_valid_o=1 next cycle, pc<=pc+4 (mod 2^XLEN, wraps), and issue next request the same cycle (back-to-back, throughput 1/ack). If stall_i=1 at ack -> go HOLD, no new request.
- HOLD: if_* outputs and pc frozen, imem_req_o=0; on stall_i falling, issue request at pc, go FETCH.
- Redirect (ex_redirect_i=1 in cycle N), highest priority over stall_i and ack:
  - flush_o=1 for exactly cycle N+1 (registered); if_valid_o=0 in N+1.
  - pc<=ex_target_i at N+1; request for target issued in N+1.
  - If a request was outstanding and unacked at N, go DISCARD: the response is dropped, then request target. Ack arriving in cycle N itself is also dropped.
  - Redirect during HOLD: clears HOLD, same handling.
  - Back-to-back redirects: the later target wins; flush_o stays high.
- DISCARD: imem_req_o=0 until stale ack, then request pc, go FETCH. Further redirects only update pc.
- imem_addr_o stable while imem_req_o=1 and unacked.
- Low two bits of ex_target_i: without the feature, forced to 0 (aligned down).
- Reset mid-transaction: state discarded, pending ack after reset ignored until first new request (IDLE issues no ack-dependent action).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: ex_target_i[1:0]!=0 -> no fetch, trap_o=1 one cycle (N+1) alongside flush_o, pc holds the misaligned value, state HOLD until next redirect (trap vector supplied by CSR logic as a redirect).
- Undefined: target aligned down silently; trap_o constant 0.

Decomposition:
- Shared package/defines: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, fetch state enum encodings.
- One sub-module natural: fetch_pc_reg (pc register with increment/redirect mux and alignment/trap check); FSM and handshake stay in the top.

Test Plan:
- Reset release, imem ack latency 1, no stalls -> requests at 0x0,0x4,0x8, if_pc_o follows with if_valid_o=1, flush_o=0.
- Redirect to 0x100 while request at 0x8 outstanding, ack 2 cycles later -> flush_o one cycle, 0x8 data never on if_instr_o, next request 0x100.
- stall_i=1 for 3 cycles at ack of 0x4 -> if_pc_o=0x4 held, imem_req_o=0, fetch 0x8 resumes after stall falls.
- Redirect asserted same cycle as stall_i and ack -> redirect wins, flush_o=1, next if_pc_o=target.
- PC at 0xFFFF_FFFC -> next fetch 0x0000_0000 (wrap).
- Target 0x102: without macro fetch 0x100; with MISALIGN_TRAP_EN trap_o=1 one cycle, no fetch until next redirect.
